// File: rtl/bitstream_loader_if.sv
// Byte stream feeding the configuration loader: valid/ready handshake carrying one config byte.
// The byte source drives through master; the loader receives through slave.
interface bitstream_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/bitstream_loader.sv
// Serialises config bytes onto the fabric chain (prog_clk/prog_en/prog_in), or in VERIFY mode
// recirculates prog_out back into the chain and counts bits that differ from the byte stream.
module bitstream_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int CLK_DIV   = 2,
    parameter int ERR_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               verify_i,
    input  logic               abort_i,
    bitstream_loader_if.slave  byte_if,
    output logic               prog_clk_o,
    output logic               prog_en_o,
    output logic               prog_in_o,
    input  logic               prog_out_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               mismatch_o,
    output logic [ERR_W-1:0]   err_cnt_o
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [7:0]       shreg_q,    shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic             verify_q,   verify_d;
    logic             prog_clk_q, prog_clk_d;
    logic             prog_en_q,  prog_en_d;
    logic             prog_in_q,  prog_in_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             mis_q,      mis_d;
    logic [ERR_W-1:0] err_q,      err_d;

    logic div_last;
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // Gated by abort so a byte offered in the aborting cycle is never seen as transferred.
    assign byte_if.byte_ready = (state_q == S_FETCH) && !abort_i;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        div_d      = div_q;
        verify_d   = verify_q;
        prog_clk_d = prog_clk_q;
        prog_en_d  = prog_en_q;
        prog_in_d  = prog_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mis_d      = mis_q;
        err_d      = err_q;

        if (abort_i && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            prog_clk_d = 1'b0;
            prog_en_d  = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d   = S_FETCH;
                        verify_d  = verify_i;
                        mis_d     = 1'b0;
                        err_d     = '0;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                        prog_en_d = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (byte_if.byte_valid) begin
                        state_d   = S_LO;
                        shreg_d   = byte_if.byte_data;
                        bit_idx_d = 3'd0;
                        div_d     = '0;
                        prog_in_d = verify_q ? prog_out_i : byte_if.byte_data[7];
                    end
                end
                S_LO: begin
                    if (div_last) begin
                        state_d    = S_HI;
                        div_d      = '0;
                        prog_clk_d = 1'b1;
                        if (verify_q && (prog_out_i != shreg_q[7])) begin
                            mis_d = 1'b1;
                            if (err_q != '1) begin
                                err_d = err_q + 1'b1;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_HI: begin
                    if (div_last) begin
                        div_d      = '0;
                        prog_clk_d = 1'b0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        shreg_d    = {shreg_q[6:0], 1'b0};
                        // Leftover low bits of a final partial byte are simply never shifted out.
                        if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                            state_d   = S_TAIL;
                            prog_en_d = 1'b0;
                            done_d    = 1'b1;
                        end else if (bit_idx_q == 3'd7) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d   = S_LO;
                            bit_idx_d = bit_idx_q + 3'd1;
                            prog_in_d = verify_q ? prog_out_i : shreg_q[6];
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_TAIL: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d    = S_IDLE;
                    prog_clk_d = 1'b0;
                    prog_en_d  = 1'b0;
                    busy_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            div_q      <= '0;
            verify_q   <= 1'b0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            prog_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            div_q      <= div_d;
            verify_q   <= verify_d;
            prog_clk_q <= prog_clk_d;
            prog_en_q  <= prog_en_d;
            prog_in_q  <= prog_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
        end
    end

    assign prog_clk_o = prog_clk_q;
    assign prog_en_o  = prog_en_q;
    assign prog_in_o  = prog_in_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mismatch_o = mis_q;
    assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Bench for bitstream_loader: a chain model on prog_clk, a byte feeder, and a stream-level model
// of the expected prog_in bits and error count, checked every cycle from the negedge.
module tb_bitstream_loader;

    localparam int CHAIN_LEN = 12;
    localparam int CLK_DIV   = 2;
    localparam int ERR_W     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic verify = 1'b0;
    logic abort = 1'b0;
    logic progClk, progEn, progIn, progOut, busy, done, mismatch;
    logic [ERR_W-1:0] errCnt;
    logic progClk1, progEn1, progIn1, busy1, done1, mismatch1;
    logic [0:0] errCnt1;

    bitstream_loader_if bif ();
    bitstream_loader_if bif1 ();
    assign bif1.byte_data  = bif.byte_data;
    assign bif1.byte_valid = bif.byte_valid;

    always #5 clk = ~clk;

    bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .CLK_DIV(CLK_DIV), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .verify_i(verify), .abort_i(abort),
        .byte_if(bif), .prog_clk_o(progClk), .prog_en_o(progEn), .prog_in_o(progIn),
        .prog_out_i(progOut), .busy_o(busy), .done_o(done), .mismatch_o(mismatch),
        .err_cnt_o(errCnt)
    );

    // Narrow-counter copy fed identically, to see the error counter saturate.
    bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .CLK_DIV(CLK_DIV), .ERR_W(1)) dutNarrow (
        .clk(clk), .rst_n(rst_n), .start_i(start), .verify_i(verify), .abort_i(abort),
        .byte_if(bif1), .prog_clk_o(progClk1), .prog_en_o(progEn1), .prog_in_o(progIn1),
        .prog_out_i(progOut), .busy_o(busy1), .done_o(done1), .mismatch_o(mismatch1),
        .err_cnt_o(errCnt1)
    );

    // Fabric chain model: shifts prog_in in on each prog_clk rise; flipStb corrupts chosen bits.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] flipMask = '0;
    logic flipStb = 1'b0;
    always @(posedge progClk or posedge flipStb) begin
        if (flipStb) chain <= chain ^ flipMask;
        else         chain <= {chain[CHAIN_LEN-2:0], progIn};
    end
    assign progOut = chain[CHAIN_LEN-1];

    int checks = 0;
    int errors = 0;
    int feedQ[$];
    int opBytes[$];
    bit expBits[$];
    int expErr = 0;
    int edgeIdx = 0;
    int doneCnt = 0;
    int busyCnt = 0;
    int accepted = 0;
    int stallCnt = 0;
    int highRun = 0;
    logic prevClk = 1'b0;
    logic [CHAIN_LEN-1:0] capBits = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte source: entries < 256 are bytes; 256+N holds valid low for N cycles.
    initial begin
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (feedQ.size() == 0) begin
                bif.byte_valid = 1'b0;
            end else if (feedQ[0] >= 256) begin
                bif.byte_valid = 1'b0;
                feedQ[0] = feedQ[0] - 1;
                if (feedQ[0] == 256) void'(feedQ.pop_front());
            end else begin
                bif.byte_valid = 1'b1;
                bif.byte_data  = 8'(feedQ[0]);
            end
            @(negedge clk);
            if (bif.byte_valid && bif.byte_ready && feedQ.size() > 0) begin
                accepted++;
                void'(feedQ.pop_front());
            end
        end
    end

    // Every-cycle comparison against the stream-level model.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevClk = 1'b0;
            highRun = 0;
        end else begin
            if (!busy) checkOutput("idle_outputs", {29'd0, progClk, progEn, bif.byte_ready}, 32'd0);
            else busyCnt++;
            if (bif.byte_ready) begin
                checkOutput("fetch_hold", {30'd0, progClk, progEn}, 32'd1);
                if (!bif.byte_valid) stallCnt++;
            end
            if (progClk && !prevClk) begin
                checkOutput("en_at_rise", progEn, 1);
                if (edgeIdx < expBits.size()) begin
                    checkOutput("prog_in_bit", progIn, expBits[edgeIdx]);
                    capBits = {capBits[CHAIN_LEN-2:0], progIn};
                end else begin
                    checkOutput("extra_rise", edgeIdx, expBits.size());
                end
                edgeIdx++;
            end
            if (progClk) begin
                highRun++;
            end else if (prevClk) begin
                checkOutput("hi_len", highRun, CLK_DIV);
                highRun = 0;
            end
            if (done) begin
                doneCnt++;
                checkOutput("done_bits", edgeIdx, CHAIN_LEN);
                checkOutput("err_cnt", errCnt, expErr);
                checkOutput("mismatch", mismatch, (expErr != 0) ? 1 : 0);
                checkOutput("err_cnt_w1", errCnt1, (expErr > 0) ? 1 : 0);
                checkOutput("mismatch_w1", mismatch1, (expErr != 0) ? 1 : 0);
            end
            prevClk = progClk;
        end
    end

    // Builds expectations from opBytes and the current chain content, then pulses start.
    task automatic applyStimulus(input bit v);
        bit stream[$];
        logic [CHAIN_LEN-1:0] snap;
        stream.delete();
        foreach (opBytes[i]) begin
            if (opBytes[i] < 256) begin
                for (int k = 7; k >= 0; k--) stream.push_back(opBytes[i][k]);
            end
        end
        snap = chain;
        expBits.delete();
        expErr = 0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (v) begin
                expBits.push_back(snap[CHAIN_LEN-1-i]);
                if (snap[CHAIN_LEN-1-i] != stream[i]) expErr++;
            end else begin
                expBits.push_back(stream[i]);
            end
        end
        edgeIdx  = 0;
        busyCnt  = 0;
        accepted = 0;
        stallCnt = 0;
        capBits  = '0;
        feedQ    = opBytes;
        @(posedge clk);
        #1;
        start  = 1'b1;
        verify = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic waitDone(input int d0);
        int n = 0;
        while (doneCnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (doneCnt == d0) checkOutput("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        feedQ.delete();
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {26'd0, progClk, progEn, progIn, busy, done, mismatch}, 32'd0);
        checkOutput("reset_err_ready", {23'd0, bif.byte_ready, errCnt}, 32'd0);
        rst_n = 1'b1;

        // LOAD 0xA5,0x3F with valid held and an extra byte queued behind them.
        $display("[TB] load A5 3F");
        d0 = doneCnt;
        opBytes = '{8'hA5, 8'h3F, 8'h77};
        applyStimulus(1'b0);
        waitDone(d0);
        checkOutput("load_done_once", doneCnt - d0, 1);
        checkOutput("load_busy_cycles", busyCnt, 51);
        checkOutput("load_bytes_taken", accepted, 2);
        checkOutput("load_prog_in_seq", capBits, 12'hA53);
        checkOutput("load_chain", chain, 12'hA53);

        // Clean VERIFY must leave the chain untouched.
        $display("[TB] verify clean");
        d0 = doneCnt;
        opBytes = '{8'hA5, 8'h30};
        applyStimulus(1'b1);
        waitDone(d0);
        checkOutput("verify_chain_kept", chain, 12'hA53);
        checkOutput("verify_err_zero", {23'd0, mismatch, errCnt}, 32'd0);

        // VERIFY against a chain with two corrupted bits.
        $display("[TB] verify with two flipped bits");
        flipMask = '0;
        flipMask[3] = 1'b1;
        flipMask[9] = 1'b1;
        #1 flipStb = 1'b1;
        #1 flipStb = 1'b0;
        d0 = doneCnt;
        opBytes = '{8'hA5, 8'h30};
        applyStimulus(1'b1);
        waitDone(d0);
        repeat (5) @(negedge clk);
        checkOutput("flip_err_cnt", errCnt, 2);
        checkOutput("flip_err_cnt_w1", errCnt1, 1);
        checkOutput("flip_mismatch_sticky", mismatch, 1);
        checkOutput("flip_chain_kept", chain, 12'hA53 ^ 12'h208);

        // LOAD with a long valid gap between bytes, plus an ignored start while busy.
        $display("[TB] load with stall");
        d0 = doneCnt;
        opBytes = '{8'hC3, 256 + 52, 8'h5A};
        applyStimulus(1'b0);
        repeat (6) @(posedge clk);
        #1;
        start  = 1'b1;
        verify = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        verify = 1'b0;
        waitDone(d0);
        checkOutput("stall_done_once", doneCnt - d0, 1);
        checkOutput("stall_seen", (stallCnt >= 15) ? 1 : 0, 1);
        checkOutput("stall_chain", chain, 12'hC35);

        // Abort after five shifted bits.
        $display("[TB] abort mid-load");
        d0 = doneCnt;
        opBytes = '{8'hF0, 8'h0F};
        applyStimulus(1'b0);
        n = 0;
        while (edgeIdx < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reach_5", (edgeIdx >= 5) ? 1 : 0, 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abort_outputs", {29'd0, progClk, progEn, busy}, 32'd0);
        feedQ.delete();
        repeat (10) @(negedge clk);
        checkOutput("abort_no_done", doneCnt - d0, 0);

        // Abort in FETCH while a byte is offered: byte must not be taken.
        opBytes = '{8'h11, 8'h22};
        applyStimulus(1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abort_fetch_no_byte", accepted, 0);
        checkOutput("abort_fetch_idle", busy, 0);
        feedQ.delete();

        // start and abort together in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_idle", busy, 0);
        repeat (3) @(negedge clk);

        // A full LOAD after the aborts.
        $display("[TB] load after abort");
        d0 = doneCnt;
        opBytes = '{8'hA5, 8'h3F};
        applyStimulus(1'b0);
        waitDone(d0);
        checkOutput("reload_done_once", doneCnt - d0, 1);
        checkOutput("reload_chain", chain, 12'hA53);

        // Asynchronous reset while prog_clk is high.
        $display("[TB] reset mid-shift");
        d0 = doneCnt;
        opBytes = '{8'hFF, 8'hFF};
        applyStimulus(1'b0);
        n = 0;
        while (!progClk && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset_reach_hi", progClk, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", {27'd0, progClk, progEn, busy, bif.byte_ready, done}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        feedQ.delete();
        repeat (10) @(negedge clk);
        checkOutput("reset_no_done", doneCnt - d0, 0);
        checkOutput("reset_stays_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
